// File: rtl/risc_pkg.sv
// Shared definitions for the multi-cycle RISC core front end:
// branch ops, instruction field positions and the fetch FSM states.
package risc_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_J    = 3'd1;
  localparam logic [2:0] BR_JR   = 3'd2;
  localparam logic [2:0] BR_BZ   = 3'd3;
  localparam logic [2:0] BR_BNZ  = 3'd4;
  localparam logic [2:0] BR_BPL  = 3'd5;
  localparam logic [2:0] BR_BMI  = 3'd6;
  localparam logic [2:0] BR_RETI = 3'd7;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int FN_MSB  = 4;
  localparam int FN_LSB  = 0;
  localparam int I16_MSB = 15;
  localparam int I26_MSB = 25;

  typedef logic [0:0] state_t;
  localparam state_t ST_FETCH = 1'b0;
  localparam state_t ST_HOLD  = 1'b1;

  // Word offsets scaled to bytes.
  function automatic logic [31:0] off16(
    input logic [15:0] i
  );
    return {{14{i[15]}}, i, 2'b00};
  endfunction

  function automatic logic [31:0] off26(
    input logic [25:0] i
  );
    return {{4{i[25]}}, i, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
// The fetch stage is the master; the memory is the slave.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_branch_resolve.sv
// Next-PC resolution from brOp. RETI returns to epc only when
// FETCH_INT_EN is defined; otherwise it falls through to PC+4.
module branch_resolve
  import risc_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [2:0]  br_op_i,
  input  logic [31:0] rs_val_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] imm26_i,
  input  logic [31:0] epc_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] seq;
  logic        taken;

  assign seq = pc_i + 32'd4;

  always_comb begin
    taken     = 1'b0;
    next_pc_o = seq;
    case (br_op_i)
      BR_J:    next_pc_o = seq + off26(imm26_i);
      BR_JR:   next_pc_o = {rs_val_i[31:2], 2'b00};
      BR_BZ:   taken = (rs_val_i == 32'd0);
      BR_BNZ:  taken = (rs_val_i != 32'd0);
      BR_BPL:  taken = ~rs_val_i[31];
      BR_BMI:  taken = rs_val_i[31];
`ifdef FETCH_INT_EN
      BR_RETI: next_pc_o = epc_i;
`endif
      default: ;
    endcase
    if (taken) next_pc_o = seq + off16(imm16_i);
  end

`ifndef FETCH_INT_EN
  logic unused_epc;
  assign unused_epc = ^epc_i;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake and held instruction.
// Interrupt vector/return logic is built only with FETCH_INT_EN.
module fetch_unit
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         INT,
  input  logic         updPC,
  input  logic [2:0]   brOp,
  input  logic [31:0]  rs_val,
  fetch_unit_if.master imem,
  output logic [31:0]  PC,
  output logic [31:0]  ins,
  output logic         ins_valid,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   func,
  output logic [15:0]  imm16,
  output logic [25:0]  imm26,
  output logic [31:0]  epc
);

  state_t      st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] next_pc;
  logic        in_fetch;
  logic        ack_take;
  logic        retire;
  logic        take_int;

  assign in_fetch = (st_q == ST_FETCH);
  assign ack_take = in_fetch & imem.imem_ack;
  assign retire   = ~in_fetch & updPC;

  // Request is gated by rst so it drops with no clock edge.
  assign imem.imem_req  = in_fetch & rst;
  assign imem.imem_addr = pc_q;

  assign PC        = pc_q;
  assign ins       = ins_q;
  assign ins_valid = ~in_fetch;
  assign opcode    = ins_q[OPC_MSB:OPC_LSB];
  assign rs        = ins_q[RS_MSB:RS_LSB];
  assign rt        = ins_q[RT_MSB:RT_LSB];
  assign rd        = ins_q[RD_MSB:RD_LSB];
  assign func      = ins_q[FN_MSB:FN_LSB];
  assign imm16     = ins_q[I16_MSB:0];
  assign imm26     = ins_q[I26_MSB:0];

  branch_resolve u_br (
    .pc_i      (pc_q),
    .br_op_i   (brOp),
    .rs_val_i  (rs_val),
    .imm16_i   (imm16),
    .imm26_i   (imm26),
    .epc_i     (epc),
    .next_pc_o (next_pc)
  );

  always_comb begin
    st_d  = st_q;
    pc_d  = pc_q;
    ins_d = ins_q;
    unique case (1'b1)
      ack_take: begin
        st_d  = ST_HOLD;
        ins_d = imem.imem_rdata;
      end
      retire: begin
        st_d = ST_FETCH;
        pc_d = take_int ? INT_VECTOR : next_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ST_FETCH;
      pc_q  <= RESET_PC;
      ins_q <= '0;
    end else begin
      st_q  <= st_d;
      pc_q  <= pc_d;
      ins_q <= ins_d;
    end
  end

`ifdef FETCH_INT_EN
  logic        int_prev_q;
  logic        int_pend_q, int_pend_d;
  logic        int_mask_q, int_mask_d;
  logic [31:0] epc_q, epc_d;

  // Never vector on RETI itself; a pending request waits one retire.
  assign take_int = retire & int_pend_q & ~int_mask_q
                  & (brOp != BR_RETI);

  always_comb begin
    int_pend_d = (int_pend_q & ~take_int) | (INT & ~int_prev_q);
    int_mask_d = int_mask_q;
    epc_d      = epc_q;
    if (take_int) begin
      int_mask_d = 1'b1;
      epc_d      = next_pc;
    end else if (retire && brOp == BR_RETI) begin
      int_mask_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_prev_q <= 1'b0;
      int_pend_q <= 1'b0;
      int_mask_q <= 1'b0;
      epc_q      <= '0;
    end else begin
      int_prev_q <= INT;
      int_pend_q <= int_pend_d;
      int_mask_q <= int_mask_d;
      epc_q      <= epc_d;
    end
  end

  assign epc = epc_q;
`else
  logic unused_int;
  assign unused_int = INT;
  assign take_int   = 1'b0;
  assign epc        = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a behavioural PC/interrupt model.
// Interrupt expectations follow FETCH_INT_EN as the design does.
module tb_fetch_unit;
  import risc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] VEC    = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        INT = 1'b0;
  logic        updPC = 1'b0;
  logic [2:0]  brOp = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] PC, ins, epc;
  logic        ins_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, func;
  logic [15:0] imm16;
  logic [25:0] imm26;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(RST_PC), .INT_VECTOR(VEC)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .updPC     (updPC),
    .brOp      (brOp),
    .rs_val    (rs_val),
    .imem      (imem_bus),
    .PC        (PC),
    .ins       (ins),
    .ins_valid (ins_valid),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .func      (func),
    .imm16     (imm16),
    .imm26     (imm26),
    .epc       (epc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_ins, m_epc;
  bit          m_pend, m_mask;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_ins  = 32'd0;
    m_epc  = 32'd0;
    m_pend = 1'b0;
    m_mask = 1'b0;
  endtask

  task automatic fetch(input int dly, input logic [31:0] w);
    for (int i = 0; i < dly; i++) begin
      chk("stall_req", 32'(imem_bus.imem_req), 32'd1);
      chk("stall_addr", imem_bus.imem_addr, m_pc);
      chk("stall_vld", 32'(ins_valid), 32'd0);
      updPC = 1'($urandom_range(0, 1));
      brOp  = 3'($urandom);
      step();
    end
    updPC = 1'b0;
    chk("req", 32'(imem_bus.imem_req), 32'd1);
    chk("addr", imem_bus.imem_addr, m_pc);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = w;
    step();
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom;
    m_ins = w;
    chk("vld", 32'(ins_valid), 32'd1);
    chk("ins", ins, w);
    chk("pc_hold", PC, m_pc);
    chk("fields", 32'({opcode, rs, rt, rd, func}),
        32'({w[31:26], w[25:21], w[20:16], w[15:11], w[4:0]}));
    chk("imm16", 32'(imm16), 32'(w[15:0]));
    chk("imm26", 32'(imm26), 32'(w[25:0]));
    if ($urandom_range(0, 2) == 0) begin
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = ~w;
      step();
      imem_bus.imem_ack = 1'b0;
      chk("hold_ins", ins, w);
      chk("hold_req", 32'(imem_bus.imem_req), 32'd0);
    end
  endtask

  task automatic int_pulse();
    INT = 1'b1;
    step();
    INT = 1'b0;
    step();
`ifdef FETCH_INT_EN
    m_pend = 1'b1;
`endif
    chk("int_vld", 32'(ins_valid), 32'd1);
  endtask

  task automatic retire(input logic [2:0] op, input logic [31:0] rv);
    logic [31:0] seq, nxt, o16, o26;
    bit          tk;
    seq = m_pc + 32'd4;
    o16 = 32'($signed(m_ins[15:0])) * 32'd4;
    o26 = 32'($signed(m_ins[25:0])) * 32'd4;
    tk  = 1'b0;
    nxt = seq;
    case (op)
      3'd1: nxt = seq + o26;
      3'd2: nxt = rv & ~32'd3;
      3'd3: tk = (rv == 0);
      3'd4: tk = (rv != 0);
      3'd5: tk = !rv[31];
      3'd6: tk = rv[31];
`ifdef FETCH_INT_EN
      3'd7: nxt = m_epc;
`endif
      default: ;
    endcase
    if (tk) nxt = seq + o16;
`ifdef FETCH_INT_EN
    if (m_pend && !m_mask && op != 3'd7) begin
      m_epc  = nxt;
      nxt    = VEC;
      m_pend = 1'b0;
      m_mask = 1'b1;
    end else if (op == 3'd7) begin
      m_mask = 1'b0;
    end
`endif
    updPC  = 1'b1;
    brOp   = op;
    rs_val = rv;
    step();
    updPC  = 1'b0;
    brOp   = 3'($urandom);
    rs_val = $urandom;
    m_pc   = nxt;
    chk("npc", PC, m_pc);
    chk("ret_vld", 32'(ins_valid), 32'd0);
    chk("ret_req", 32'(imem_bus.imem_req), 32'd1);
    chk("ret_addr", imem_bus.imem_addr, m_pc);
    chk("ret_ins", ins, m_ins);
    chk("epc", epc, m_epc);
  endtask

  task automatic check_reset_outs();
    chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
    chk("rst_pc", PC, RST_PC);
    chk("rst_ins", ins, 32'd0);
    chk("rst_vld", 32'(ins_valid), 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_op", 32'(opcode), 32'd0);
  endtask

  localparam logic [31:0] W_BR = 32'h0000_FFFE;
  localparam logic [31:0] W_J  = 32'h03FF_FFFF;

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    model_reset();
    #1;
    check_reset_outs();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("first_req", 32'(imem_bus.imem_req), 32'd1);
    chk("first_addr", imem_bus.imem_addr, RST_PC);

    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_bus.imem_addr, 32'(i * 4));
      fetch(0, 32'd0);
      retire(BR_NONE, 32'd0);
    end
    chk("at_10", PC, 32'h10);

    fetch(0, W_BR);
    retire(BR_BZ, 32'd0);
    chk("bz_taken", PC, 32'h0C);
    fetch(1, 32'd0);
    retire(BR_NONE, 32'd0);
    fetch(0, W_BR);
    retire(BR_BZ, 32'd5);
    chk("bz_not", PC, 32'h14);
    fetch(0, 32'd0);
    retire(BR_JR, 32'h10);
    fetch(0, W_BR);
    retire(BR_BMI, 32'h8000_0000);
    chk("bmi_taken", PC, 32'h0C);
    fetch(0, 32'd0);
    retire(BR_JR, 32'h203);
    chk("jr", PC, 32'h200);
    fetch(0, 32'd0);
    retire(BR_JR, 32'd0);
    fetch(0, W_J);
    retire(BR_J, 32'd0);
    chk("j_back", PC, 32'h0);

    fetch(0, 32'd0);
    retire(BR_JR, 32'h20);
    fetch(0, 32'd0);
    int_pulse();
    retire(BR_NONE, 32'd0);
`ifdef FETCH_INT_EN
    chk("int_vec", PC, VEC);
    chk("int_epc", epc, 32'h24);
`else
    chk("noint_pc", PC, 32'h24);
`endif
    fetch(0, 32'd0);
    int_pulse();
    retire(BR_NONE, 32'd0);
    fetch(0, 32'd0);
    retire(BR_RETI, 32'd0);
`ifdef FETCH_INT_EN
    chk("reti", PC, 32'h24);
`endif
    fetch(0, 32'd0);
    retire(BR_NONE, 32'd0);
`ifdef FETCH_INT_EN
    chk("int2_vec", PC, VEC);
    chk("int2_epc", epc, 32'h28);
`endif
    fetch(0, 32'd0);
    retire(BR_RETI, 32'd0);

    fetch(5, $urandom);
    retire(BR_NONE, 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] rv;
      fetch($urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) int_pulse();
      case ($urandom_range(0, 2))
        0: rv = 32'd0;
        1: rv = 32'h8000_0000;
        default: rv = $urandom;
      endcase
      retire(3'($urandom_range(0, 7)), rv);
    end

    step();
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outs();
    step();
    rst = 1'b1;
    #1;
    chk("rel_req", 32'(imem_bus.imem_req), 32'd1);
    chk("rel_addr", imem_bus.imem_addr, RST_PC);
    fetch(0, 32'd0);
    retire(BR_NONE, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
